// File: rtl/vga_rx_monitor_if.sv
// Signal bundle between a VGA pixel source and the receive-side timing monitor.
// The source drives the sampled stream; the monitor returns lock status and pixel capture.
interface vga_rx_monitor_if;
    logic        pix_ce;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] vga_rgb;
    logic        locked;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        pix_valid;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic [18:0] lit_count;
    logic        sync_err;

    modport master (
        output pix_ce, vga_hs, vga_vs, vga_rgb,
        input  locked, h_total, v_total, pix_valid, x_pos, y_pos, pix_rgb,
               frame_done, lit_count, sync_err
    );

    modport slave (
        input  pix_ce, vga_hs, vga_vs, vga_rgb,
        output locked, h_total, v_total, pix_valid, x_pos, y_pos, pix_rgb,
               frame_done, lit_count, sync_err
    );
endinterface

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: measures line/frame periods, locks on stable timing,
// then reports active-pixel coordinates, sampled colour and a per-frame lit-pixel count.
module vga_rx_monitor #(
    parameter int unsigned H_ACT_START = 142,
    parameter int unsigned V_ACT_START = 33,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_rx_monitor_if.slave vga
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX = '1;
    localparam logic [10:0] H_LO    = 11'(H_ACT_START);
    localparam logic [10:0] H_HI    = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_ACT_START);
    localparam logic [10:0] V_HI    = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    state_t      r_state, w_state_next;
    logic        r_hs, r_vs, r_vs_pend;
    logic [10:0] r_h_cnt, r_v_cnt, r_h_total, r_v_total;
    logic [3:0]  r_lock_cnt;
    logic        r_ref_valid, r_first, r_line_bad;
    logic [18:0] r_acc, r_lit;
    logic        r_pix_valid, r_frame_done, r_sync_err;
    logic [9:0]  r_x, r_y;
    logic [11:0] r_rgb;

    logic        w_hs_fall, w_vs_fall, w_line0, w_timeout;
    logic [10:0] w_h_next, w_v_next, w_line_len, w_frame_len;
    logic        w_line_mm, w_frame_mm, w_frame_ok, w_lose, w_active, w_locked;
    logic [3:0]  w_lock_inc;

    assign w_hs_fall   = r_hs & ~vga.vga_hs;
    assign w_vs_fall   = r_vs & ~vga.vga_vs;
    assign w_line0     = w_hs_fall & (r_vs_pend | w_vs_fall);
    assign w_timeout   = ~w_hs_fall & (r_h_cnt == CNT_MAX - 11'd1);
    assign w_line_len  = r_h_cnt + 11'd1;
    assign w_frame_len = r_v_cnt + 11'd1;
    assign w_h_next    = w_hs_fall ? '0 : ((r_h_cnt == CNT_MAX) ? CNT_MAX : w_line_len);
    assign w_v_next    = !w_hs_fall ? r_v_cnt :
                         w_line0 ? '0 : ((r_v_cnt == CNT_MAX) ? CNT_MAX : w_frame_len);
    // The first HS fall after entering MEASURE only seeds h_total; it is never a mismatch.
    assign w_line_mm   = w_hs_fall & ~r_first & (w_line_len != r_h_total);
    assign w_frame_mm  = w_line0 & (w_frame_len != r_v_total);
    assign w_frame_ok  = ~w_frame_mm & ~w_line_mm & ~r_line_bad;
    assign w_lock_inc  = r_lock_cnt + 4'd1;
    assign w_lose      = vga.pix_ce & (r_state == LOCKED) & (w_line_mm | w_frame_mm | w_timeout);
    assign w_active    = (r_state == LOCKED) & ~w_lose &
                         (w_h_next >= H_LO) & (w_h_next < H_HI) &
                         (w_v_next >= V_LO) & (w_v_next < V_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SEARCH;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (vga.pix_ce) begin
            case (r_state)
                SEARCH:  if (w_line0) w_state_next = MEASURE;
                MEASURE: begin
                    if (w_timeout)
                        w_state_next = SEARCH;
                    else if (w_line0 && r_ref_valid && w_frame_ok && (w_lock_inc == LOCK_N))
                        w_state_next = LOCKED;
                end
                LOCKED:  if (w_lose) w_state_next = SEARCH;
                default: w_state_next = SEARCH;
            endcase
        end
    end

    always_comb begin
        w_locked = (r_state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_vs_pend <= 1'b0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else if (vga.pix_ce) begin
            r_hs      <= vga.vga_hs;
            r_vs      <= vga.vga_vs;
            r_vs_pend <= (r_vs_pend | w_vs_fall) & ~w_hs_fall;
            r_h_cnt   <= w_h_next;
            r_v_cnt   <= w_v_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_total   <= '0;
            r_v_total   <= '0;
            r_lock_cnt  <= '0;
            r_ref_valid <= 1'b0;
            r_first     <= 1'b0;
            r_line_bad  <= 1'b0;
        end else if (vga.pix_ce) begin
            if (r_state == SEARCH) begin
                if (w_line0) begin
                    r_lock_cnt  <= '0;
                    r_ref_valid <= 1'b0;
                    r_first     <= 1'b1;
                    r_line_bad  <= 1'b0;
                end
            end else if (r_state == MEASURE) begin
                if (w_hs_fall) begin
                    if (r_first) begin
                        r_h_total <= w_line_len;
                        r_first   <= 1'b0;
                    end else if (w_line_mm) begin
                        r_h_total  <= w_line_len;
                        r_lock_cnt <= '0;
                        r_line_bad <= 1'b1;
                    end
                end
                if (w_line0) begin
                    r_line_bad <= 1'b0;
                    if (!r_ref_valid) begin
                        r_v_total   <= w_frame_len;
                        r_ref_valid <= 1'b1;
                    end else if (w_frame_ok) begin
                        r_lock_cnt <= w_lock_inc;
                    end else begin
                        r_v_total  <= w_frame_len;
                        r_lock_cnt <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_rgb        <= '0;
            r_acc        <= '0;
            r_lit        <= '0;
        end else begin
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (vga.pix_ce) begin
                if (w_active) begin
                    r_pix_valid <= 1'b1;
                    r_x         <= 10'(w_h_next - H_LO);
                    r_y         <= 10'(w_v_next - V_LO);
                    r_rgb       <= vga.vga_rgb;
                end
                if (w_lose) begin
                    r_acc      <= '0;
                    r_sync_err <= 1'b1;
                end else if ((r_state == LOCKED) && w_line0) begin
                    r_lit        <= r_acc;
                    r_frame_done <= 1'b1;
                    r_acc        <= '0;
                end else if ((r_state != LOCKED) && (w_state_next == LOCKED)) begin
                    r_acc <= '0;
                end else if (w_active && (vga.vga_rgb != '0)) begin
                    r_acc <= r_acc + 19'd1;
                end
            end
        end
    end

    assign vga.locked     = w_locked;
    assign vga.h_total    = r_h_total;
    assign vga.v_total    = r_v_total;
    assign vga.pix_valid  = r_pix_valid;
    assign vga.x_pos      = r_x;
    assign vga.y_pos      = r_y;
    assign vga.pix_rgb    = r_rgb;
    assign vga.frame_done = r_frame_done;
    assign vga.lit_count  = r_lit;
    assign vga.sync_err   = r_sync_err;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a small raster: 16-tick lines (HS low ticks 1-3),
// 8-line frames (VS low lines 0-1), active window 8x4 starting at h_cnt=4, v_cnt=2.
module tb_vga_rx_monitor;
    localparam int LINE  = 16;
    localparam int LINES = 8;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_rx_monitor_if vif();

    vga_rx_monitor #(
        .H_ACT_START(4),
        .V_ACT_START(2),
        .H_ACTIVE   (8),
        .V_ACTIVE   (4),
        .LOCK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif)
    );

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          exp_acc = 0;
    pix_t        q_pix[$];
    logic [18:0] q_fd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".locked"},     32'(vif.locked), 0);
        chk({tag, ".h_total"},    32'(vif.h_total), 0);
        chk({tag, ".v_total"},    32'(vif.v_total), 0);
        chk({tag, ".pix_valid"},  32'(vif.pix_valid), 0);
        chk({tag, ".x_pos"},      32'(vif.x_pos), 0);
        chk({tag, ".y_pos"},      32'(vif.y_pos), 0);
        chk({tag, ".pix_rgb"},    32'(vif.pix_rgb), 0);
        chk({tag, ".frame_done"}, 32'(vif.frame_done), 0);
        chk({tag, ".lit_count"},  32'(vif.lit_count), 0);
        chk({tag, ".sync_err"},   32'(vif.sync_err), 0);
    endtask

    // Monitor: every strobe from the DUT is matched against the oldest expectation.
    initial begin
        pix_t        e;
        logic [18:0] f;
        forever begin
            @(negedge clk);
            if (vif.pix_valid) begin
                if (q_pix.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pix_unexpected: got strobe at (%0d,%0d), expected none at %0t",
                             vif.x_pos, vif.y_pos, $time);
                end else begin
                    e = q_pix.pop_front();
                    chk("pixel{x,y,rgb}", {vif.x_pos, vif.y_pos, vif.pix_rgb}, e);
                end
            end
            if (vif.frame_done) begin
                if (q_fd.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_done_unexpected: got lit_count=%0d, expected no pulse at %0t",
                             vif.lit_count, $time);
                end else begin
                    f = q_fd.pop_front();
                    chk("lit_count", 32'(vif.lit_count), 32'(f));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        vif.vga_hs  = hs;
        vif.vga_vs  = vs;
        vif.vga_rgb = rgb;
        vif.pix_ce  = 1'b1;
        @(negedge clk);
        vif.pix_ce  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // mode 0: solid F00, 1: only (3,2) lit, 2: {x,y,0} (pixel (0,0) is black).
    task automatic send_frame(input bit lk, input bit fd, input int mode,
                              input int short_line, input int stop_line);
        int          len, x, y;
        bit          act;
        logic        hs, vs;
        logic [11:0] rgb;
        pix_t        e;
        for (int l = 0; l < LINES; l++) begin
            len = (l == short_line) ? LINE - 1 : LINE;
            for (int t = 0; t < len; t++) begin
                if (l == stop_line && t == 9) return;
                hs  = !(t >= 1 && t <= 3);
                vs  = !(l <= 1);
                x   = t - 5;
                y   = l - 2;
                act = (x >= 0 && x < 8 && y >= 0 && y < 4);
                case (mode)
                    0:       rgb = 12'hF00;
                    1:       rgb = (x == 3 && y == 2) ? 12'h5A3 : 12'h000;
                    default: rgb = {4'(x), 4'(y), 4'h0};
                endcase
                if (!act) rgb = 12'h00F;
                if (l == 0 && t == 1) begin
                    if (fd) q_fd.push_back(19'(exp_acc));
                    exp_acc = 0;
                end
                if (act && lk && !(short_line >= 0 && l > short_line)) begin
                    e.x   = 10'(x);
                    e.y   = 10'(y);
                    e.rgb = rgb;
                    q_pix.push_back(e);
                    if (rgb != 12'h000) exp_acc++;
                end
                tick(hs, vs, rgb);
                if (l == 0 && t == 1) chk("locked_at_frame_start", 32'(vif.locked), 32'(lk));
                if (short_line >= 0 && l == short_line + 1 && t == 1) begin
                    chk("locked_after_glitch",   32'(vif.locked), 0);
                    chk("sync_err_after_glitch", 32'(vif.sync_err), 1);
                end
            end
        end
    endtask

    initial begin
        vif.pix_ce  = 1'b0;
        vif.vga_hs  = 1'b1;
        vif.vga_vs  = 1'b1;
        vif.vga_rgb = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        repeat (3) send_frame(0, 0, 0, -1, -1);
        send_frame(1, 0, 0, -1, -1);
        chk("h_total", 32'(vif.h_total), 16);
        chk("v_total", 32'(vif.v_total), 8);
        send_frame(1, 1, 1, -1, -1);
        chk("lit_solid", 32'(vif.lit_count), 32);
        send_frame(1, 1, 2, -1, -1);
        chk("lit_sparse", 32'(vif.lit_count), 1);
        send_frame(1, 1, 0, 3, -1);
        chk("lit_pattern", 32'(vif.lit_count), 31);
        chk("sync_err_sticky", 32'(vif.sync_err), 1);

        repeat (3) send_frame(0, 0, 0, -1, -1);
        send_frame(1, 0, 0, -1, -1);
        chk("sync_err_after_relock", 32'(vif.sync_err), 1);
        send_frame(1, 1, 0, -1, 3);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (3) send_frame(0, 0, 0, -1, -1);
        send_frame(1, 0, 0, -1, -1);
        chk("sync_err_before_timeout", 32'(vif.sync_err), 0);
        for (int k = 1; k <= 2100; k++) begin
            tick(1'b1, 1'b1, 12'h00F);
            if (k == 2032) chk("locked_before_timeout", 32'(vif.locked), 1);
            if (k == 2033) begin
                chk("locked_after_timeout",   32'(vif.locked), 0);
                chk("sync_err_after_timeout", 32'(vif.sync_err), 1);
            end
        end

        repeat (8) @(negedge clk);
        chk("pix_queue_drained", 32'(q_pix.size()), 0);
        chk("fd_queue_drained",  32'(q_fd.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
